// File: rtl/reg_bus_poller.sv
// reg_bus_poller: register-bus read initiator.
// Periodically (or on a start pulse) sweeps NUM_REGS consecutive 32-bit
// registers starting at BASE_ADDR. Each register gets one read: a single-cycle
// rd strobe with addr. The returned word, or 32'hDEADBEEF if the read times
// out, is then presented with its index on a valid/ready stream.
//
// Ports:
//   aclk, resetn         clock, asynchronous active-low reset
//   enable               periodic polling enable (one sweep per PERIOD_CLKS)
//   start                one-cycle pulse requesting an immediate sweep
//   addr, rd             read request toward responders (addr is 0 outside rd)
//   rdata, rvalid        read response
//   m_data, m_index,
//   m_last, m_valid,
//   m_ready              output stream, one word per register
//   busy                 sweep in progress
//   timeout_err          sticky read-timeout flag, cleared by start
//   m_tstamp             sweep start timestamp (only with POLLER_TIMESTAMP_EN)
//
// Optional feature macro: POLLER_TIMESTAMP_EN adds m_tstamp, a free-running
// cycle counter value latched when each sweep leaves IDLE.

module reg_bus_poller #(
  parameter int unsigned               ADDR_WIDTH   = 30,
  parameter logic [ADDR_WIDTH-1:0]     BASE_ADDR    = ADDR_WIDTH'(30'h10000000),
  parameter int unsigned               NUM_REGS     = 4,
  parameter int unsigned               PERIOD_CLKS  = 1000000,
  parameter int unsigned               TIMEOUT_CLKS = 16
) (
  input  logic                  aclk,
  input  logic                  resetn,
  input  logic                  enable,
  input  logic                  start,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic                  rd,
  input  logic [31:0]           rdata,
  input  logic                  rvalid,
  output logic [31:0]           m_data,
  output logic [7:0]            m_index,
  output logic                  m_last,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic                  busy,
  output logic                  timeout_err
`ifdef POLLER_TIMESTAMP_EN
  ,
  output logic [31:0]           m_tstamp
`endif
);

  localparam int unsigned IDX_W = 8;
  localparam int unsigned TO_W  = $clog2(TIMEOUT_CLKS + 1);
  localparam int unsigned PT_W  = (PERIOD_CLKS > 1) ? $clog2(PERIOD_CLKS) : 1;

  localparam logic [IDX_W-1:0] LAST_IDX     = IDX_W'(NUM_REGS - 1);
  localparam logic [TO_W-1:0]  TO_LIMIT     = TO_W'(TIMEOUT_CLKS);
  localparam logic [PT_W-1:0]  PT_LAST      = PT_W'(PERIOD_CLKS - 1);
  localparam logic [31:0]      TIMEOUT_WORD = 32'hDEADBEEF;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_PUSH  = 2'd3
  } state_t;

  state_t                r_state, w_state_nxt;
  logic [IDX_W-1:0]      r_idx, w_idx_nxt;
  logic [TO_W-1:0]       r_tcnt, w_tcnt_nxt;
  logic [ADDR_WIDTH-1:0] r_addr, w_addr_nxt;
  logic                  r_rd, w_rd_nxt;
  logic [31:0]           r_data, w_data_nxt;
  logic [IDX_W-1:0]      r_index, w_index_nxt;
  logic                  r_last, w_last_nxt;
  logic                  r_valid, w_valid_nxt;
  logic                  r_busy, w_busy_nxt;
  logic                  r_terr, w_terr_nxt;

  logic                  r_pending;
  logic                  w_take;
  logic [PT_W-1:0]       r_ptimer;
  logic                  w_wrap;

  // Period timer: counts only while enabled, wrap requests a sweep.
  assign w_wrap = enable && (r_ptimer == PT_LAST);

  always_ff @(posedge aclk or negedge resetn) begin
    if (!resetn) begin
      r_ptimer <= '0;
    end else if (!enable || w_wrap) begin
      r_ptimer <= '0;
    end else begin
      r_ptimer <= r_ptimer + PT_W'(1);
    end
  end

  // Single pending request; a request coinciding with the take is absorbed
  // by the sweep that is starting.
  always_ff @(posedge aclk or negedge resetn) begin
    if (!resetn) begin
      r_pending <= 1'b0;
    end else if (w_take) begin
      r_pending <= 1'b0;
    end else if (start || w_wrap) begin
      r_pending <= 1'b1;
    end
  end

  // FSM state and registered outputs.
  always_ff @(posedge aclk or negedge resetn) begin
    if (!resetn) begin
      r_state <= S_IDLE;
      r_idx   <= '0;
      r_tcnt  <= '0;
      r_addr  <= '0;
      r_rd    <= 1'b0;
      r_data  <= '0;
      r_index <= '0;
      r_last  <= 1'b0;
      r_valid <= 1'b0;
      r_busy  <= 1'b0;
      r_terr  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
      r_tcnt  <= w_tcnt_nxt;
      r_addr  <= w_addr_nxt;
      r_rd    <= w_rd_nxt;
      r_data  <= w_data_nxt;
      r_index <= w_index_nxt;
      r_last  <= w_last_nxt;
      r_valid <= w_valid_nxt;
      r_busy  <= w_busy_nxt;
      r_terr  <= w_terr_nxt;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_tcnt_nxt  = r_tcnt;
    w_addr_nxt  = '0;
    w_rd_nxt    = 1'b0;
    w_data_nxt  = r_data;
    w_index_nxt = r_index;
    w_last_nxt  = r_last;
    w_valid_nxt = r_valid;
    w_busy_nxt  = r_busy;
    w_terr_nxt  = start ? 1'b0 : r_terr;
    w_take      = 1'b0;

    unique case (r_state)
      S_IDLE: begin
        if (r_pending) begin
          w_take      = 1'b1;
          w_idx_nxt   = '0;
          w_busy_nxt  = 1'b1;
          w_rd_nxt    = 1'b1;
          w_state_nxt = S_ISSUE;
        end
      end
      S_ISSUE: begin
        // Counter holds cycles elapsed since the rd strobe.
        w_tcnt_nxt  = TO_W'(1);
        w_state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (rvalid || (r_tcnt == TO_LIMIT)) begin
          // rvalid takes priority over a coincident timeout.
          if (rvalid) begin
            w_data_nxt = rdata;
          end else begin
            w_data_nxt = TIMEOUT_WORD;
            w_terr_nxt = 1'b1;
          end
          w_index_nxt = r_idx;
          w_last_nxt  = (r_idx == LAST_IDX);
          w_valid_nxt = 1'b1;
          w_state_nxt = S_PUSH;
        end else begin
          w_tcnt_nxt = r_tcnt + TO_W'(1);
        end
      end
      S_PUSH: begin
        if (m_ready) begin
          w_valid_nxt = 1'b0;
          if (r_idx == LAST_IDX) begin
            w_busy_nxt  = 1'b0;
            w_state_nxt = S_IDLE;
          end else begin
            w_idx_nxt   = r_idx + IDX_W'(1);
            w_rd_nxt    = 1'b1;
            w_state_nxt = S_ISSUE;
          end
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase

    // Address is only driven alongside the strobe; wraps modulo 2^ADDR_WIDTH.
    if (w_rd_nxt) begin
      w_addr_nxt = BASE_ADDR + ADDR_WIDTH'(w_idx_nxt);
    end
  end

  assign addr        = r_addr;
  assign rd          = r_rd;
  assign m_data      = r_data;
  assign m_index     = r_index;
  assign m_last      = r_last;
  assign m_valid     = r_valid;
  assign busy        = r_busy;
  assign timeout_err = r_terr;

`ifdef POLLER_TIMESTAMP_EN
  logic [31:0] r_cycles;
  logic [31:0] r_tstamp;

  // Free-running cycle counter, sampled once per sweep start.
  always_ff @(posedge aclk or negedge resetn) begin
    if (!resetn) begin
      r_cycles <= '0;
      r_tstamp <= '0;
    end else begin
      r_cycles <= r_cycles + 32'd1;
      if (w_take) begin
        r_tstamp <= r_cycles;
      end
    end
  end

  assign m_tstamp = r_tstamp;
`endif

endmodule

// File: tb/tb_reg_bus_poller.sv
// Directed testbench for reg_bus_poller with a scripted register responder.
module tb_reg_bus_poller;

  localparam int unsigned AW   = 30;
  localparam int          NR   = 4;
  localparam logic [29:0] BASE = 30'h10000000;

  logic          aclk = 1'b0;
  logic          resetn, enable, start, m_ready;
  logic [AW-1:0] addr;
  logic          rd;
  logic [31:0]   rdata = 32'h0;
  logic          rvalid = 1'b0;
  logic [31:0]   m_data;
  logic [7:0]    m_index;
  logic          m_last, m_valid, busy, timeout_err;
`ifdef POLLER_TIMESTAMP_EN
  logic [31:0]   m_tstamp;
`endif

  reg_bus_poller #(
    .ADDR_WIDTH  (AW),
    .BASE_ADDR   (BASE),
    .NUM_REGS    (4),
    .PERIOD_CLKS (200),
    .TIMEOUT_CLKS(16)
  ) dut (
    .aclk       (aclk),
    .resetn     (resetn),
    .enable     (enable),
    .start      (start),
    .addr       (addr),
    .rd         (rd),
    .rdata      (rdata),
    .rvalid     (rvalid),
    .m_data     (m_data),
    .m_index    (m_index),
    .m_last     (m_last),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .busy       (busy),
    .timeout_err(timeout_err)
`ifdef POLLER_TIMESTAMP_EN
    ,
    .m_tstamp   (m_tstamp)
`endif
  );

  always #5 aclk = ~aclk;

  int cyc = 0;
  always @(posedge aclk) cyc <= cyc + 1;

  int n_vec = 0;
  int n_err = 0;

  // Responder: answers register i with 0x100+i, resp_delay[i] cycles after rd
  // (0 = never answers).
  typedef struct {
    int          due;
    logic [31:0] data;
  } resp_t;
  resp_t resp_q[$];
  int    resp_delay[NR];

  always @(posedge aclk) begin
    logic [29:0] off;
    int          ix;
    #1;
    rvalid = 1'b0;
    rdata  = 32'h0;
    if (!resetn) begin
      resp_q.delete();
    end else begin
      foreach (resp_q[i]) begin
        if (resp_q[i].due == cyc) begin
          rvalid = 1'b1;
          rdata  = resp_q[i].data;
        end
      end
      if (rd) begin
        off = addr - BASE;
        ix  = int'(off);
        if (ix >= 0 && ix < NR && resp_delay[ix] != 0)
          resp_q.push_back('{due: cyc + resp_delay[ix], data: 32'h100 + 32'(ix)});
      end
    end
  end

  // Monitor: records rd strobes and stream handshakes mid-cycle.
  int          rd_cyc[$];
  logic [29:0] rd_addr[$];
  int          hs_cyc[$];
  logic [31:0] hs_data[$];
  logic [7:0]  hs_idx[$];
  logic        hs_last[$];
  logic [31:0] hs_ts[$];

  always @(negedge aclk) begin
    if (resetn) begin
      if (rd) begin
        rd_cyc.push_back(cyc);
        rd_addr.push_back(addr);
      end
      if (m_valid && m_ready) begin
        hs_cyc.push_back(cyc);
        hs_data.push_back(m_data);
        hs_idx.push_back(m_index);
        hs_last.push_back(m_last);
`ifdef POLLER_TIMESTAMP_EN
        hs_ts.push_back(m_tstamp);
`else
        hs_ts.push_back(32'h0);
`endif
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic clr();
    rd_cyc.delete(); rd_addr.delete();
    hs_cyc.delete(); hs_data.delete(); hs_idx.delete(); hs_last.delete(); hs_ts.delete();
  endtask

  task automatic wait_hs(input string tag, input int n, input int budget);
    int k = 0;
    while (hs_data.size() < n && k < budget) begin
      tick();
      k++;
    end
    chk(tag, 32'(hs_data.size()), 32'(n));
  endtask

  task automatic wait_valid(input string tag, input int budget);
    int k = 0;
    while (!m_valid && k < budget) begin
      tick();
      k++;
    end
    chk(tag, 32'(m_valid), 32'd1);
  endtask

  // Checks one 4-word sweep recorded starting at queue offset b.
  task automatic chk_sweep(input string tag, input int b, input logic [31:0] w2);
    logic [31:0] exp;
    for (int i = 0; i < NR; i++) begin
      exp = (i == 2) ? w2 : 32'h100 + 32'(i);
      if (b + i < hs_data.size()) begin
        chk({tag, "_data"}, hs_data[b+i], exp);
        chk({tag, "_idx"},  32'(hs_idx[b+i]), 32'(i));
        chk({tag, "_last"}, 32'(hs_last[b+i]), 32'(i == NR - 1));
      end else begin
        chk({tag, "_missing"}, 32'(hs_data.size()), 32'(b + i + 1));
      end
      if (b + i < rd_addr.size())
        chk({tag, "_addr"}, 32'(rd_addr[b+i]), 32'(BASE + 30'(i)));
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          c1, nrd, bad;
    logic [31:0] held;
    resetn = 1'b0; enable = 1'b0; start = 1'b0; m_ready = 1'b1;
    foreach (resp_delay[i]) resp_delay[i] = 2;

    // Reset state
    tick(); tick(); tick();
    chk("rst_addr",  32'(addr), 32'h0);
    chk("rst_rd",    32'(rd), 32'h0);
    chk("rst_data",  m_data, 32'h0);
    chk("rst_index", 32'(m_index), 32'h0);
    chk("rst_last",  32'(m_last), 32'h0);
    chk("rst_valid", 32'(m_valid), 32'h0);
    chk("rst_busy",  32'(busy), 32'h0);
    chk("rst_terr",  32'(timeout_err), 32'h0);
    resetn = 1'b1;
    tick(); tick();

    // Basic sweep on start
    clr();
    pulse_start();
    wait_hs("basic_wait", 4, 100);
    chk("basic_busy", 32'(busy), 32'h0);
    chk_sweep("basic", 0, 32'h102);
    chk("basic_rd2mv",  32'(hs_cyc[0] - rd_cyc[0]), 32'd3);
    chk("basic_hs2rd",  32'(rd_cyc[1] - hs_cyc[0]), 32'd1);
    chk("basic_terr",   32'(timeout_err), 32'h0);

    // Register 2 never answers
    resp_delay[2] = 0;
    clr();
    pulse_start();
    wait_hs("to_wait", 4, 150);
    chk_sweep("to", 0, 32'hDEADBEEF);
    chk("to_terr",   32'(timeout_err), 32'h1);
    chk("to_rd2mv",  32'(hs_cyc[2] - rd_cyc[2]), 32'd17);
    chk("to_hs2rd",  32'(rd_cyc[3] - hs_cyc[2]), 32'd1);
    chk("to_busy",   32'(busy), 32'h0);

    // Start clears the flag; rvalid exactly at the timeout limit wins
    resp_delay[0] = 16; resp_delay[2] = 2;
    clr();
    pulse_start();
    chk("clr_terr", 32'(timeout_err), 32'h0);
    wait_hs("edge_wait", 4, 150);
    chk_sweep("edge", 0, 32'h102);
    chk("edge_rd2mv", 32'(hs_cyc[0] - rd_cyc[0]), 32'd17);
    chk("edge_terr",  32'(timeout_err), 32'h0);
    resp_delay[0] = 2;

    // Back-pressure: hold word 1 for 50 cycles
    clr();
    m_ready = 1'b0;
    pulse_start();
    wait_valid("stall_w0", 50);
    chk("stall_idx0", 32'(m_index), 32'd0);
    m_ready = 1'b1;
    tick();
    m_ready = 1'b0;
    wait_valid("stall_w1", 50);
    chk("stall_idx1", 32'(m_index), 32'd1);
    held = m_data;
    nrd  = rd_cyc.size();
    bad  = 0;
    repeat (50) begin
      tick();
      if (m_data !== held || m_index !== 8'd1 || m_valid !== 1'b1) bad++;
    end
    chk("stall_stable", 32'(bad), 32'd0);
    chk("stall_held",   held, 32'h101);
    chk("stall_no_rd",  32'(rd_cyc.size()), 32'(nrd));
    m_ready = 1'b1;
    wait_hs("stall_wait", 4, 100);
    chk_sweep("stall", 0, 32'h102);
    chk("stall_hs2rd", 32'(rd_cyc[2] - hs_cyc[1]), 32'd1);

    // Periodic polling, then enable dropped during the third sweep
    clr();
    enable = 1'b1;
    c1 = 0;
    while (rd_cyc.size() < 9 && c1 < 700) begin
      tick();
      c1++;
    end
    chk("per_reach", 32'(rd_cyc.size()), 32'd9);
    enable = 1'b0;
    repeat (450) tick();
    chk("per_rdcnt", 32'(rd_cyc.size()), 32'd12);
    chk("per_hscnt", 32'(hs_data.size()), 32'd12);
    chk("per_busy",  32'(busy), 32'h0);
    if (rd_cyc.size() >= 9) begin
      chk("per_gap1", 32'(rd_cyc[4] - rd_cyc[0]), 32'd200);
      chk("per_gap2", 32'(rd_cyc[8] - rd_cyc[4]), 32'd200);
    end
    chk_sweep("per3", 8, 32'h102);

    // Asynchronous reset while waiting for a response
    clr();
    pulse_start();
    c1 = 0;
    while (!rd && c1 < 10) begin
      tick();
      c1++;
    end
    chk("arst_rd_seen", 32'(rd), 32'h1);
    tick();
    resetn = 1'b0;
    #1;
    chk("arst_addr",  32'(addr), 32'h0);
    chk("arst_rd",    32'(rd), 32'h0);
    chk("arst_data",  m_data, 32'h0);
    chk("arst_index", 32'(m_index), 32'h0);
    chk("arst_last",  32'(m_last), 32'h0);
    chk("arst_valid", 32'(m_valid), 32'h0);
    chk("arst_busy",  32'(busy), 32'h0);
    chk("arst_terr",  32'(timeout_err), 32'h0);
    tick(); tick();
    resetn = 1'b1;
    clr();
    tick(); tick(); tick();
    chk("arst_quiet", 32'(m_valid), 32'h0);
    pulse_start();
    wait_hs("arst_wait", 4, 100);
    chk_sweep("arst", 0, 32'h102);

`ifdef POLLER_TIMESTAMP_EN
    // Timestamps of two sweeps started 500 cycles apart
    clr();
    c1 = cyc;
    pulse_start();
    wait_hs("ts_wait1", 4, 100);
    while (cyc < c1 + 500) tick();
    pulse_start();
    wait_hs("ts_wait2", 8, 100);
    chk("ts_const1", hs_ts[3], hs_ts[0]);
    chk("ts_const2", hs_ts[7], hs_ts[4]);
    chk("ts_delta",  hs_ts[4] - hs_ts[0], 32'd500);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
